// File: rtl/sramlike_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sramlike_mem_arbiter_pkg
//   Shared types and widths for the SRAM-like memory arbiter slice.
//   - ADDR_W / DATA_W / BEN_W : bus widths of every SRAM-like port
//   - src_e                   : request source ID stored in the in-order ID FIFO
//   - ptr_w()                 : pointer width for a FIFO of a given depth (>=1 bit)
// -----------------------------------------------------------------------------
package sramlike_mem_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BEN_W  = 4;
  localparam int SRC_W  = 1;

  typedef enum logic [SRC_W-1:0] {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sramlike_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// sramlike_mem_arbiter_if
//   One SRAM-like bus: request phase (req/addr/ben/wr/din, addr_ok) and
//   response phase (data_ok/dout).
//   modport master : drives the request, receives addr_ok/data_ok/dout
//   modport slave  : receives the request, drives addr_ok/data_ok/dout
// -----------------------------------------------------------------------------
interface sramlike_mem_arbiter_if;
  import sramlike_mem_arbiter_pkg::*;

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic [BEN_W-1:0]  ben;
  logic              wr;
  logic [DATA_W-1:0] din;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] dout;

  modport master (
    output req, addr, ben, wr, din,
    input  addr_ok, data_ok, dout
  );

  modport slave (
    input  req, addr, ben, wr, din,
    output addr_ok, data_ok, dout
  );

endinterface

// File: rtl/sramlike_mem_arbiter_id_fifo.sv
// -----------------------------------------------------------------------------
// mem_arb_id_fifo
//   In-order FIFO of request source IDs. One entry per accepted-but-unanswered
//   memory request; the head names the master owed the next response.
//   Ports:
//     clk, rst       clock, asynchronous active-high reset (pointers/count)
//     push, push_id  append an ID (caller guarantees !full)
//     pop            drop the head (caller guarantees !empty)
//     head_id        ID at the head
//     empty, full    occupancy flags
// -----------------------------------------------------------------------------
module mem_arb_id_fifo
  import sramlike_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  src_e push_id,
  input  logic pop,
  output src_e head_id,
  output logic empty,
  output logic full
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  src_e             id_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr] <= push_id;
  end

  assign head_id = id_mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/sramlike_mem_arbiter.sv
// -----------------------------------------------------------------------------
// sramlike_mem_arbiter
//   Shares one SRAM-like memory port between the instruction-fetch master and
//   the load/store master. Request phases are arbitrated (round-robin or data
//   priority), the source of every accepted request is queued in order, and
//   each returning response is routed to the master at the head of that queue.
//   Parameters:
//     MAX_OUTSTANDING  accepted-but-unanswered requests allowed (>=1)
//     DATA_PRIO        0 = round-robin on ties, 1 = data master always wins
//   Ports:
//     clk, rst    clock, asynchronous active-high reset
//     inst        instruction master bus (slave side)
//     data        load/store master bus (slave side)
//     mem         memory bus (master side)
//     orphan_err  sticky: a memory response arrived with nothing outstanding
// -----------------------------------------------------------------------------
module sramlike_mem_arbiter
  import sramlike_mem_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter bit DATA_PRIO       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  sramlike_mem_arbiter_if.slave  inst,
  sramlike_mem_arbiter_if.slave  data,
  sramlike_mem_arbiter_if.master mem,
  output logic                  orphan_err
);

  logic lock;
  src_e lock_src;
  src_e rr_last;

  logic gnt_vld;
  src_e gnt_src;
  logic accept;
  logic pop;

  src_e head_id;
  logic fifo_empty;
  logic fifo_full;

  // A pending (locked) request always keeps the bus, even when the FIFO is
  // full, so the memory never sees a request withdrawn or swapped.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_src = SRC_INST;
    if (lock) begin
      gnt_vld = 1'b1;
      gnt_src = lock_src;
    end else if (!fifo_full) begin
      if (inst.req && data.req) begin
        gnt_vld = 1'b1;
        if (DATA_PRIO) gnt_src = SRC_DATA;
        else           gnt_src = (rr_last == SRC_DATA) ? SRC_INST : SRC_DATA;
      end else if (inst.req) begin
        gnt_vld = 1'b1;
        gnt_src = SRC_INST;
      end else if (data.req) begin
        gnt_vld = 1'b1;
        gnt_src = SRC_DATA;
      end
    end
    if (rst) gnt_vld = 1'b0;
  end

  // Request mux; falls back to the inst fields when nothing is granted.
  always_comb begin
    mem.req = gnt_vld;
    if (gnt_src == SRC_DATA) begin
      mem.addr = data.addr;
      mem.ben  = data.ben;
      mem.wr   = data.wr;
      mem.din  = data.din;
    end else begin
      mem.addr = inst.addr;
      mem.ben  = inst.ben;
      mem.wr   = inst.wr;
      mem.din  = inst.din;
    end
  end

  assign accept       = gnt_vld & mem.addr_ok;
  assign inst.addr_ok = accept & (gnt_src == SRC_INST);
  assign data.addr_ok = accept & (gnt_src == SRC_DATA);

  // Responses with an empty FIFO are orphans and are not forwarded.
  assign pop          = mem.data_ok & ~fifo_empty & ~rst;
  assign inst.data_ok = pop & (head_id == SRC_INST);
  assign data.data_ok = pop & (head_id == SRC_DATA);
  assign inst.dout    = mem.dout;
  assign data.dout    = mem.dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock       <= 1'b0;
      lock_src   <= SRC_INST;
      rr_last    <= SRC_DATA;
      orphan_err <= 1'b0;
    end else begin
      if (accept) begin
        lock    <= 1'b0;
        rr_last <= gnt_src;
      end else if (gnt_vld) begin
        lock     <= 1'b1;
        lock_src <= gnt_src;
      end
      if (mem.data_ok && fifo_empty) orphan_err <= 1'b1;
    end
  end

  mem_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accept),
    .push_id (gnt_src),
    .pop     (pop),
    .head_id (head_id),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

endmodule
